// File: rtl/vga_sync_decoder.sv
// Recovers pixel coordinates and line/frame timing from an active-low VGA sync pair
// (same clock domain) and declares lock once consecutive frames match the expected mode.
module vga_sync_decoder #(
  parameter int EXP_H_TOTAL = 1040,
  parameter int EXP_H_SYNC  = 128,
  parameter int EXP_V_TOTAL = 666,
  parameter int EXP_V_SYNC  = 4,
  parameter int H_ACTIVE    = 800,
  parameter int V_ACTIVE    = 600,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        iCLK,
  input  logic        iRST_N,
  input  logic        iH_SYNC,
  input  logic        iV_SYNC,
  output logic [10:0] oPX,
  output logic [9:0]  oPY,
  output logic        oDE,
  output logic [10:0] oH_TOTAL,
  output logic [10:0] oH_SYNC_W,
  output logic [9:0]  oV_TOTAL,
  output logic [9:0]  oV_SYNC_W,
  output logic        oLOCKED,
  output logic        oFRAME_START,
  output logic        oERR
);

  typedef enum logic {ST_UNLOCKED, ST_LOCKED} state_e;

  localparam logic [10:0] H_MAX   = 11'd2047;
  localparam logic [9:0]  V_MAX   = 10'd1023;
  localparam logic [10:0] EXP_HT  = 11'(EXP_H_TOTAL);
  localparam logic [10:0] EXP_HS  = 11'(EXP_H_SYNC);
  localparam logic [9:0]  EXP_VT  = 10'(EXP_V_TOTAL);
  localparam logic [9:0]  EXP_VS  = 10'(EXP_V_SYNC);
  localparam logic [10:0] H_ACT   = 11'(H_ACTIVE);
  localparam logic [9:0]  V_ACT   = 10'(V_ACTIVE);
  localparam logic [2:0]  LOCK_N  = 3'(LOCK_FRAMES);

  state_e      state_q, state_d;
  logic        hs_q, hs_d, vs_q, vs_d;
  logic [10:0] h_cnt_q, h_cnt_d;
  logic [9:0]  v_cnt_q, v_cnt_d;
  logic        h_seen_q, h_seen_d, v_seen_q, v_seen_d;
  logic [10:0] h_total_q, h_total_d, h_sync_w_q, h_sync_w_d;
  logic [9:0]  v_total_q, v_total_d, v_sync_w_q, v_sync_w_d;
  logic        line_bad_q, line_bad_d;
  logic [2:0]  good_cnt_q, good_cnt_d;
  logic        frame_start_q, frame_start_d, err_q, err_d;

  logic        hfall, hrise, vfall, vrise, timeout, bad_now, frame_ok;
  logic [10:0] h_meas;
  logic [9:0]  v_meas;

  always_comb begin
    hfall    = hs_q & ~iH_SYNC;
    hrise    = ~hs_q & iH_SYNC;
    vfall    = hfall & vs_q & ~iV_SYNC;
    vrise    = hfall & ~vs_q & iV_SYNC;
    h_meas   = h_cnt_q + 11'd1;
    v_meas   = v_cnt_q + 10'd1;
    // Fires only on the step into saturation, so a dead hsync reports once.
    timeout  = ~hfall & (h_cnt_q == H_MAX - 11'd1);
    bad_now  = h_seen_q & ((hfall & (h_meas != EXP_HT)) | (hrise & (h_meas != EXP_HS)));
    frame_ok = ~(line_bad_q | bad_now) & (v_meas == EXP_VT) & (v_sync_w_q == EXP_VS);

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    hs_d          = iH_SYNC;
    vs_d          = vs_q;
    h_cnt_d       = hfall ? 11'd0 : ((h_cnt_q == H_MAX) ? H_MAX : h_meas);
    v_cnt_d       = v_cnt_q;
    h_seen_d      = h_seen_q | hfall;
    v_seen_d      = v_seen_q;
    h_total_d     = h_total_q;
    h_sync_w_d    = h_sync_w_q;
    v_total_d     = v_total_q;
    v_sync_w_d    = v_sync_w_q;
    line_bad_d    = line_bad_q | bad_now;
    good_cnt_d    = good_cnt_q;
    state_d       = state_q;
    frame_start_d = 1'b0;
    err_d         = 1'b0;

    if (hfall && h_seen_q) h_total_d  = h_meas;
    if (hrise && h_seen_q) h_sync_w_d = h_meas;

    // Vertical timing is measured in lines, so it only moves on hsync falls.
    if (hfall) begin
      vs_d = iV_SYNC;
      if (vfall) begin
        v_cnt_d       = 10'd0;
        frame_start_d = 1'b1;
        line_bad_d    = 1'b0;
        v_seen_d      = 1'b1;
        if (v_seen_q) begin
          v_total_d = v_meas;
          unique case (state_q)
            ST_UNLOCKED: begin
              if (frame_ok) begin
                good_cnt_d = good_cnt_q + 3'd1;
                if (good_cnt_d == LOCK_N) state_d = ST_LOCKED;
              end else begin
                good_cnt_d = 3'd0;
              end
            end
            ST_LOCKED: begin
              if (!frame_ok) begin
                state_d    = ST_UNLOCKED;
                good_cnt_d = 3'd0;
                err_d      = 1'b1;
              end
            end
          endcase
        end
      end else begin
        v_cnt_d = (v_cnt_q == V_MAX) ? V_MAX : v_meas;
        if (vrise) v_sync_w_d = v_meas;
      end
    end

    if (timeout) begin
      h_seen_d   = 1'b0;
      v_seen_d   = 1'b0;
      good_cnt_d = 3'd0;
      line_bad_d = 1'b0;
      state_d    = ST_UNLOCKED;
      err_d      = (state_q == ST_LOCKED);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q       <= ST_UNLOCKED;
      hs_q          <= 1'b1;
      vs_q          <= 1'b1;
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      h_seen_q      <= 1'b0;
      v_seen_q      <= 1'b0;
      h_total_q     <= '0;
      h_sync_w_q    <= '0;
      v_total_q     <= '0;
      v_sync_w_q    <= '0;
      line_bad_q    <= 1'b0;
      good_cnt_q    <= '0;
      frame_start_q <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      hs_q          <= hs_d;
      vs_q          <= vs_d;
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      h_seen_q      <= h_seen_d;
      v_seen_q      <= v_seen_d;
      h_total_q     <= h_total_d;
      h_sync_w_q    <= h_sync_w_d;
      v_total_q     <= v_total_d;
      v_sync_w_q    <= v_sync_w_d;
      line_bad_q    <= line_bad_d;
      good_cnt_q    <= good_cnt_d;
      frame_start_q <= frame_start_d;
      err_q         <= err_d;
    end
  end

  assign oPX          = h_cnt_q;
  assign oPY          = v_cnt_q;
  assign oH_TOTAL     = h_total_q;
  assign oH_SYNC_W    = h_sync_w_q;
  assign oV_TOTAL     = v_total_q;
  assign oV_SYNC_W    = v_sync_w_q;
  assign oLOCKED      = (state_q == ST_LOCKED);
  assign oFRAME_START = frame_start_q;
  assign oERR         = err_q;
  assign oDE          = oLOCKED & (h_cnt_q < H_ACT) & (v_cnt_q < V_ACT);

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Bench for vga_sync_decoder in a scaled-down mode (40 clocks x 12 lines) so whole
// frames stay short; the 11/10-bit counters and the 2047-clock timeout are unchanged.
`timescale 1ns/1ps
module tb_vga_sync_decoder;

  localparam int HT = 40, HS = 6, VT = 12, VS = 2, HA = 30, VA = 9, LF = 2;
  localparam int BIG = 1 << 30;

  logic        iCLK = 1'b0, iRST_N = 1'b0, iH_SYNC = 1'b1, iV_SYNC = 1'b1;
  logic [10:0] oPX, oH_TOTAL, oH_SYNC_W;
  logic [9:0]  oPY, oV_TOTAL, oV_SYNC_W;
  logic        oDE, oLOCKED, oFRAME_START, oERR;

  int n_checks = 0, n_errors = 0, err_pulses = 0;
  bit cmp_en = 1'b0;

  always #5 iCLK = ~iCLK;

  vga_sync_decoder #(
    .EXP_H_TOTAL(HT), .EXP_H_SYNC(HS), .EXP_V_TOTAL(VT), .EXP_V_SYNC(VS),
    .H_ACTIVE(HA), .V_ACTIVE(VA), .LOCK_FRAMES(LF)
  ) dut (
    .iCLK(iCLK), .iRST_N(iRST_N), .iH_SYNC(iH_SYNC), .iV_SYNC(iV_SYNC),
    .oPX(oPX), .oPY(oPY), .oDE(oDE), .oH_TOTAL(oH_TOTAL), .oH_SYNC_W(oH_SYNC_W),
    .oV_TOTAL(oV_TOTAL), .oV_SYNC_W(oV_SYNC_W), .oLOCKED(oLOCKED),
    .oFRAME_START(oFRAME_START), .oERR(oERR)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: timing expressed as timestamps (clock edge index of the last
  // hsync fall, line index of the last vsync fall) rather than running counters.
  int e = 0, t_hf = 0, nl = 0, t_vf = 0, good = 0, age = 0, lines = 0;
  int m_px = 0, m_py = 0, m_htot = 0, m_hsw = 0, m_vtot = 0, m_vsw = 0;
  bit hs_p = 1'b1, vs_p = 1'b1, h_seen = 1'b0, v_seen = 1'b0, frame_bad = 1'b0;
  bit m_locked = 1'b0, m_fs = 1'b0, m_err = 1'b0, hf, hr, vf, vr, ok;

  always @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      e = 0; t_hf = 0; nl = 0; t_vf = 0; good = 0;
      hs_p = 1'b1; vs_p = 1'b1; h_seen = 1'b0; v_seen = 1'b0; frame_bad = 1'b0;
      m_locked = 1'b0; m_fs = 1'b0; m_err = 1'b0;
      m_htot = 0; m_hsw = 0; m_vtot = 0; m_vsw = 0; m_px = 0; m_py = 0;
    end else begin
      m_fs = 1'b0; m_err = 1'b0;
      e++;
      hf = hs_p & ~iH_SYNC;
      hr = ~hs_p & iH_SYNC;
      hs_p = iH_SYNC;
      age = e - t_hf;
      if (hf) begin
        if (h_seen) begin
          m_htot = age;
          if (age != HT) frame_bad = 1'b1;
        end
        h_seen = 1'b1;
        t_hf = e;
        vf = vs_p & ~iV_SYNC;
        vr = ~vs_p & iV_SYNC;
        vs_p = iV_SYNC;
        nl++;
        lines = nl - t_vf;
        if (vf) begin
          if (v_seen) begin
            m_vtot = (lines >= 1024) ? 0 : lines;
            ok = !frame_bad && m_vtot == VT && m_vsw == VS;
            if (m_locked) begin
              if (!ok) begin m_locked = 1'b0; good = 0; m_err = 1'b1; end
            end else if (ok) begin
              good++;
              if (good == LF) m_locked = 1'b1;
            end else begin
              good = 0;
            end
          end
          v_seen = 1'b1; frame_bad = 1'b0; t_vf = nl; m_fs = 1'b1;
        end else if (vr) begin
          m_vsw = (lines >= 1024) ? 0 : lines;
        end
      end else begin
        if (hr && h_seen) begin
          m_hsw = age;
          if (age != HS) frame_bad = 1'b1;
        end
        if (age == 2047) begin
          m_err = m_locked; m_locked = 1'b0;
          h_seen = 1'b0; v_seen = 1'b0; good = 0; frame_bad = 1'b0;
        end
      end
      m_px = (e - t_hf > 2047) ? 2047 : e - t_hf;
      m_py = (nl - t_vf > 1023) ? 1023 : nl - t_vf;
    end
  end

  always @(negedge iCLK) begin
    if (cmp_en) begin
      check("px", oPX, m_px);
      check("py", oPY, m_py);
      check("de", oDE, (m_locked && m_px < HA && m_py < VA) ? 1 : 0);
      check("h_total", oH_TOTAL, m_htot);
      check("h_sync_w", oH_SYNC_W, m_hsw);
      check("v_total", oV_TOTAL, m_vtot);
      check("v_sync_w", oV_SYNC_W, m_vsw);
      check("locked", oLOCKED, m_locked);
      check("frame_start", oFRAME_START, m_fs);
      check("err", oERR, m_err);
    end
    if (oERR === 1'b1) err_pulses++;
  end

  task automatic drive(input logic h, input logic v);
    iH_SYNC = h;
    iV_SYNC = v;
    @(posedge iCLK);
    #2;
  endtask

  // Drives cycles [from, to) of one frame; line 'bad' is one clock short.
  task automatic frame_part(input int ln, input int vsw, input int hsw, input int bad,
                            input int from, input int to);
    int c;
    c = 0;
    for (int l = 0; l < ln; l++) begin
      for (int i = 0; i < ((l == bad) ? HT - 1 : HT); i++) begin
        if (c >= from && c < to) drive(i >= hsw, l >= vsw);
        c++;
      end
    end
  endtask

  task automatic frame(input int ln, input int vsw, input int hsw, input int bad);
    frame_part(ln, vsw, hsw, bad, 0, BIG);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_px"}, oPX, 0);
    check({tag, "_py"}, oPY, 0);
    check({tag, "_de"}, oDE, 0);
    check({tag, "_h_total"}, oH_TOTAL, 0);
    check({tag, "_h_sync_w"}, oH_SYNC_W, 0);
    check({tag, "_v_total"}, oV_TOTAL, 0);
    check({tag, "_v_sync_w"}, oV_SYNC_W, 0);
    check({tag, "_locked"}, oLOCKED, 0);
    check({tag, "_frame_start"}, oFRAME_START, 0);
    check({tag, "_err"}, oERR, 0);
  endtask

  // From an unlocked, unseen state: lock appears right after the third vsync fall.
  task automatic lock_from_cold(input string tag);
    frame(VT, VS, HS, -1);
    frame(VT, VS, HS, -1);
    check({tag, "_not_locked_yet"}, oLOCKED, 0);
    frame_part(VT, VS, HS, -1, 0, 1);
    check({tag, "_locked_3rd_vfall"}, oLOCKED, 1);
    check({tag, "_frame_start"}, oFRAME_START, 1);
    frame_part(VT, VS, HS, -1, 1, BIG);
  endtask

  initial begin
    int b, b_end, rl, ln, vw, hw, bd;

    repeat (3) @(posedge iCLK);
    #2;
    cmp_en = 1'b1;
    check_zero("reset");
    iRST_N = 1'b1;
    repeat ($urandom_range(2, 20)) drive(1'b1, 1'b1);

    // Nominal stream from reset
    lock_from_cold("nominal");
    check("nom_h_total", oH_TOTAL, HT);
    check("nom_h_sync_w", oH_SYNC_W, HS);
    check("nom_v_total", oV_TOTAL, VT);
    check("nom_v_sync_w", oV_SYNC_W, VS);

    // Pixel coordinate recovery and data enable
    frame_part(VT, VS, HS, -1, 0, 1);
    check("px_first", oPX, 0);
    check("py_first", oPY, 0);
    check("de_first", oDE, 1);
    frame_part(VT, VS, HS, -1, 1, HA);
    check("px_last_active", oPX, HA - 1);
    check("de_last_active", oDE, 1);
    frame_part(VT, VS, HS, -1, HA, HA + 1);
    check("px_first_blank", oPX, HA);
    check("de_first_blank", oDE, 0);
    frame_part(VT, VS, HS, -1, HA + 1, HT + 1);
    check("py_line1", oPY, 1);
    frame_part(VT, VS, HS, -1, HT + 1, BIG);

    // One short line while locked
    b = $urandom_range(3, VT - 3);
    b_end = b * HT + HT - 1;
    frame_part(VT, VS, HS, b, 0, b_end + 1);
    check("short_h_total", oH_TOTAL, HT - 1);
    check("short_still_locked", oLOCKED, 1);
    frame_part(VT, VS, HS, b, b_end + 1, BIG);
    frame_part(VT, VS, HS, -1, 0, 1);
    check("short_unlock", oLOCKED, 0);
    check("short_err_pulse", oERR, 1);
    frame_part(VT, VS, HS, -1, 1, 2);
    check("short_err_clear", oERR, 0);
    frame_part(VT, VS, HS, -1, 2, BIG);
    frame_part(VT, VS, HS, -1, 0, 1);
    check("short_relock_wait", oLOCKED, 0);
    frame_part(VT, VS, HS, -1, 1, BIG);
    frame_part(VT, VS, HS, -1, 0, 1);
    check("short_relocked", oLOCKED, 1);
    frame_part(VT, VS, HS, -1, 1, BIG);

    // Dead hsync timeout
    err_pulses = 0;
    repeat (3000) drive(1'b1, 1'b1);
    check("timeout_px_sat", oPX, 2047);
    check("timeout_unlocked", oLOCKED, 0);
    check("timeout_err_count", err_pulses, 1);
    lock_from_cold("after_timeout");

    // Reset mid-frame while locked
    rl = $urandom_range(HT * 2, HT * VT - 2);
    frame_part(VT, VS, HS, -1, 0, rl);
    check("pre_reset_locked", oLOCKED, 1);
    iRST_N = 1'b0;
    #1;
    check_zero("mid_reset");
    repeat (3) drive(1'b1, 1'b1);
    iRST_N = 1'b1;
    repeat ($urandom_range(1, 10)) drive(1'b1, 1'b1);
    lock_from_cold("after_reset");

    // Wrong vsync width never locks and never flags an error
    iRST_N = 1'b0;
    repeat (2) drive(1'b1, 1'b1);
    iRST_N = 1'b1;
    drive(1'b1, 1'b1);
    err_pulses = 0;
    repeat (4) frame(VT, VS + 1, HS, -1);
    check("wide_vs_width", oV_SYNC_W, VS + 1);
    check("wide_vs_unlocked", oLOCKED, 0);
    check("wide_vs_no_err", err_pulses, 0);

    // Randomized timing disturbances, checked cycle by cycle against the model
    repeat (14) begin
      ln = ($urandom_range(0, 3) == 0) ? VT - 1 + $urandom_range(0, 2) : VT;
      vw = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : VS;
      hw = ($urandom_range(0, 3) == 0) ? $urandom_range(4, 8) : HS;
      bd = ($urandom_range(0, 3) == 0) ? $urandom_range(0, ln - 1) : -1;
      frame(ln, vw, hw, bd);
    end
    repeat (3) frame(VT, VS, HS, -1);
    check("final_locked", oLOCKED, 1);

    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
